// File: rtl/md_iter.sv
// Iterative HI/LO multiply-divide unit: multi-cycle multiply plus
// restoring radix-2 divide with sign fixup, MTHI/MTLO writes and flush.
module md_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             sgn;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             neg_q;
  logic             neg_r;

  logic [2*WIDTH-1:0] ma;
  logic [2*WIDTH-1:0] mb;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  // Sign-extending both operands lets one 2W-bit multiply serve both forms.
  always_comb begin
    ma      = {{WIDTH{sgn & opa[WIDTH-1]}}, opa};
    mb      = {{WIDTH{sgn & opb[WIDTH-1]}}, opb};
    prod    = ma * mb;
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, opb};
    a_neg   = sgn & opa[WIDTH-1];
    b_neg   = sgn & opb[WIDTH-1];
    abs_a   = a_neg ? -opa : opa;
    abs_b   = b_neg ? -opb : opb;
    q_fix   = neg_q ? -quo : quo;
    r_fix   = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      sgn   <= 1'b0;
      quo   <= '0;
      rem   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !flush) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                opa   <= a;
                opb   <= b;
                sgn   <= (op == OP_MULT);
                cnt   <= '0;
                state <= MUL;
                busy  <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                opa   <= a;
                opb   <= b;
                sgn   <= (op == OP_DIV);
                cnt   <= '0;
                state <= DIV;
                busy  <= 1'b1;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == MUL_LAST) begin
            {hi, lo} <= prod;
            done     <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            quo   <= abs_a;
            opb   <= abs_b;
            rem   <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            cnt   <= cnt + 1'b1;
          end else if (cnt == DIV_LAST) begin
            // opb holds |b|, so zero here means the original divisor was zero
            if (opb == '0) begin
              lo <= '1;
              hi <= opa;
            end else begin
              lo <= q_fix;
              hi <= r_fix;
            end
            done  <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            if (!diff[WIDTH]) begin
              rem <= diff[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= shifted[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_iter.sv
// Scoreboard bench for md_iter: directed multiply/divide vectors,
// MTHI/MTLO, flush, reset abort and back-to-back issue.
module tb_md_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  md_iter #(.WIDTH(W), .MUL_LAT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   bcnt   = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      bcnt = 0;
    end else if (done) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_done hi=%h lo=%h", hi, lo);
      end else begin
        e = sb.pop_front();
        if (hi !== e.hi || lo !== e.lo || bcnt != e.lat) begin
          n_miss++;
          $display("FAIL result got hi=%h lo=%h busy=%0d want hi=%h lo=%h busy=%0d",
                   hi, lo, bcnt, e.hi, e.lo, e.lat);
        end
      end
      bcnt = 0;
    end else if (busy) begin
      bcnt++;
    end else begin
      bcnt = 0;
    end
  end

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic expect_res(input logic [W-1:0] h, input logic [W-1:0] l,
                            input int lat);
    exp_t e;
    e.hi = h;
    e.lo = l;
    e.lat = lat;
    sb.push_back(e);
  endtask

  // Drives one request across an edge, then scrambles operands.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_miss++;
      $display("FAIL timeout busy stuck");
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic [W-1:0] h,
                     input logic [W-1:0] l, input int lat);
    expect_res(h, l, lat);
    issue(o, x, y);
    wait_idle();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);

    run(3'd0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 4);
    run(3'd1, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 4);
    run(3'd0, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1, 4);
    run(3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 4);
    run(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 4);
    run(3'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
    run(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 34);
    run(3'd3, 32'h00001234, 32'h0, 32'h00001234, 32'hFFFFFFFF, 34);
    run(3'd2, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 34);
    run(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 34);
    run(3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 34);

    issue(3'd4, 32'h11, 32'h0);
    check("mthi_hi", hi, 32'h11);
    check("mthi_busy", {31'b0, busy}, 32'h0);
    issue(3'd5, 32'h22, 32'h0);
    check("mtlo_lo", lo, 32'h22);
    check("mtlo_hi", hi, 32'h11);

    issue(3'd6, 32'h55, 32'h1);
    check("nop_busy", {31'b0, busy}, 32'h0);

    // Flush in busy cycle 10, with a start pulse mid-flight.
    issue(3'd3, 32'd1000, 32'd3);
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; op = 3'd5; a = 32'hDEAD;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_start_lo", lo, 32'h22);
    repeat (5) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'h0);
    check("flush_done", {31'b0, done}, 32'h0);
    check("flush_hi", hi, 32'h11);
    check("flush_lo", lo, 32'h22);

    flush = 1'b1; start = 1'b1; op = 3'd4; a = 32'h99;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("idle_flush_hi", hi, 32'h11);
    check("idle_flush_busy", {31'b0, busy}, 32'h0);

    // Reset in busy cycle 2 of a multiply.
    issue(3'd0, 32'd3, 32'd5);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    check("rst_mid_done", {31'b0, done}, 32'h0);
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);

    // The second issue lands on the done cycle of the first.
    run(3'd0, 32'd6, 32'd7, 32'h0, 32'd42, 4);
    check("b2b_done", {31'b0, done}, 32'h1);
    run(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 4);
    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/md_iter.md
MD_ITER -- requirements
Module: md_iter

Interface
REQ-001 Parameter WIDTH, default 32, meaning operand, HI and LO width; legal range 8..64, even.
REQ-002 Parameter MUL_LAT, default 4, meaning multiply busy cycles; legal range 1..8.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port start  input  1  request; sampled only when busy=0.
REQ-006 Port op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-007 Port a  input  WIDTH  operand A (dividend / MTHI-MTLO data).
REQ-008 Port b  input  WIDTH  operand B (divisor).
REQ-009 Port flush  input  1  abort the in-flight operation.
REQ-010 Port busy  output  1  operation in flight; the pipeline stalls any MFHI/MFLO/MD op while high.
REQ-011 Port done  output  1  one-cycle pulse after HI/LO update by a MULT/MULTU/DIV/DIVU.
REQ-012 Port hi  output  WIDTH  HI register contents.
REQ-013 Port lo  output  WIDTH  LO register contents.

Function
REQ-014 The FSM SHALL have states IDLE, MUL, DIV; busy=1 exactly in MUL and DIV.
REQ-015 Acceptance: start=1 in IDLE with op 0-5 at edge E; start while busy or op 6-7 is ignored.
REQ-016 MTHI/MTLO SHALL write a into hi/lo at E, stay in IDLE, and not pulse done.
REQ-017 MULT/MULTU: latch operands at E, busy=1 for exactly MUL_LAT cycles, then {hi,lo} = full 2*WIDTH product, signed for MULT, unsigned for MULTU.
REQ-018 DIV/DIVU: busy=1 for exactly WIDTH+2 cycles (1 magnitude cycle, WIDTH restoring radix-2 iterations, 1 sign-fixup cycle), then lo=quotient and hi=remainder.
REQ-019 Signed divide SHALL truncate toward zero; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-020 Signed overflow (a = most negative, b = -1) SHALL give lo = a, hi = 0.
REQ-021 Divide by zero (either op) SHALL give lo = all ones, hi = a; same latency as a normal divide.
REQ-022 hi/lo SHALL update on the edge that ends the last busy cycle. In the following cycle busy=0, done=1 and the new values are visible.
REQ-023 A new start is legal in the same cycle that done=1.
REQ-024 hi/lo SHALL not change during MUL/DIV until the final update; intermediate results live in internal registers only.
REQ-025 flush=1 in MUL/DIV SHALL return the FSM to IDLE at that edge, leave hi/lo unchanged and suppress done. A start in the same cycle is ignored.
REQ-026 flush=1 in IDLE SHALL have no effect; a simultaneous start is ignored.
REQ-027 Operands SHALL be captured at acceptance; a/b changes while busy have no effect.

Reset
REQ-028 rst=1 at an edge SHALL set state=IDLE, busy=0, done=0, hi=0, lo=0, clear internal iteration counter and partial results; rst overrides start and flush.
REQ-029 rst asserted mid-operation SHALL abort it with no HI/LO update and no done pulse.

Verification (WIDTH=32, MUL_LAT=4)
REQ-030 MULT a=0xFFFFFFFF, b=2 -> busy high 4 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulse 1 cycle.
REQ-031 MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 4 busy cycles.
REQ-032 DIV a=0xFFFFFFF9 (-7), b=2 -> busy 34 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 DIVU a=0x00001234, b=0 -> lo=0xFFFFFFFF, hi=0x00001234 after 34 cycles.
REQ-034 Load hi=0x11, lo=0x22 via MTHI/MTLO; start DIVU; flush in busy cycle 10 -> busy=0 next cycle, hi=0x11, lo=0x22, no done; start pulses while busy ignored.
REQ-035 rst in busy cycle 2 of MULT -> next cycle busy=0, done=0, hi=0, lo=0; back-to-back MULT issued on the done cycle accepted.
